// File: rtl/spi_pkg.sv
// Shared constants and types for the 24-bit SPI link.
//   SPI_FRAME_BITS : bits per frame (8-bit address + 16-bit data)
//   SPI_ADDR_W     : address field width
//   SPI_DATA_W     : data field width
//   SPI_CNT_W      : width of the target's bit counter (counts 0..25)
//   spi_slv_state_t: target FSM states
package spi_pkg;

  localparam int unsigned SPI_FRAME_BITS = 24;
  localparam int unsigned SPI_ADDR_W     = 8;
  localparam int unsigned SPI_DATA_W     = 16;
  localparam int unsigned SPI_CNT_W      = 5;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } spi_slv_state_t;

endpackage

// File: rtl/spi_slv_sync.sv
// Two-flop synchronizer plus one history flop and edge detector for one
// asynchronous SPI pin.
// Ports:
//   clk, resetn : local clock, asynchronous active-low reset
//   din         : raw asynchronous pin
//   level       : synchronized level
//   rise, fall  : one-cycle strobes on synchronized edges
module spi_slv_sync (
  input  logic clk,
  input  logic resetn,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta_q, sync_q, hist_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      hist_q <= 1'b0;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
      hist_q <= sync_q;
    end
  end

  assign level = sync_q;
  assign rise  = sync_q & ~hist_q;
  assign fall  = ~sync_q & hist_q;

endmodule

// File: rtl/spi_slave_24bit_intf.sv
// SPI target terminating 24-bit frames (8-bit address, 16-bit data, MSB
// first, active-low CS). All pins are oversampled in the clk domain.
// Optional feature macro: SPI_SLV_FRAME_CHECK_EN -- when defined, frames
// that are not exactly frame_bits long are rejected with frame_err; when
// undefined every frame is published and frame_err is tied low.
// Ports:
//   clk, resetn       : system clock (>= 8x SCLK), async active-low reset
//   SCLK, CS, MOSI    : SPI pins from the master (asynchronous)
//   MISO              : serial response to the master
//   tx_data           : response word, captured at frame start
//   rx_addr, rx_data  : fields of the last published frame
//   rx_valid          : one-cycle strobe when a frame is published
//   frame_err         : one-cycle strobe when a frame is rejected
//   busy              : high from frame start until the frame is closed
module spi_slave_24bit_intf
  import spi_pkg::*;
#(
  parameter bit          sample_rise = 1'b1,
  parameter int unsigned frame_bits  = SPI_FRAME_BITS
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  SCLK,
  input  logic                  CS,
  input  logic                  MOSI,
  output logic                  MISO,
  input  logic [frame_bits-1:0] tx_data,
  output logic [SPI_ADDR_W-1:0] rx_addr,
  output logic [SPI_DATA_W-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  frame_err,
  output logic                  busy
);

  localparam logic [SPI_CNT_W-1:0] CntFull = SPI_CNT_W'(frame_bits);
  localparam logic [SPI_CNT_W-1:0] CntMax  = SPI_CNT_W'(frame_bits + 1);

  logic sclk_level, sclk_rise, sclk_fall;
  logic cs_level, cs_rise, cs_fall;
  logic mosi_level, mosi_rise, mosi_fall;

  spi_slv_sync u_sync_sclk (
    .clk    (clk),
    .resetn (resetn),
    .din    (SCLK),
    .level  (sclk_level),
    .rise   (sclk_rise),
    .fall   (sclk_fall)
  );

  spi_slv_sync u_sync_cs (
    .clk    (clk),
    .resetn (resetn),
    .din    (CS),
    .level  (cs_level),
    .rise   (cs_rise),
    .fall   (cs_fall)
  );

  spi_slv_sync u_sync_mosi (
    .clk    (clk),
    .resetn (resetn),
    .din    (MOSI),
    .level  (mosi_level),
    .rise   (mosi_rise),
    .fall   (mosi_fall)
  );

  // Only edges are needed for SCLK/CS and only the level for MOSI.
  logic unused_sync;
  assign unused_sync = sclk_level ^ cs_level ^ mosi_rise ^ mosi_fall;

  logic sample_edge, drive_edge;
  assign sample_edge = sample_rise ? sclk_rise : sclk_fall;
  assign drive_edge  = sample_rise ? sclk_fall : sclk_rise;

  spi_slv_state_t        state_q, state_d;
  logic [frame_bits-1:0] tx_sh_q, tx_sh_d;
  logic [frame_bits-1:0] rx_sh_q, rx_sh_d;
  logic [SPI_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic                  miso_q, miso_d;
  logic [SPI_ADDR_W-1:0] rx_addr_q, rx_addr_d;
  logic [SPI_DATA_W-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  frame_err_d;
  logic                  busy_q, busy_d;

  always_comb begin
    state_d     = state_q;
    tx_sh_d     = tx_sh_q;
    rx_sh_d     = rx_sh_q;
    bit_cnt_d   = bit_cnt_q;
    miso_d      = miso_q;
    rx_addr_d   = rx_addr_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    busy_d      = busy_q;

    unique case (state_q)
      IDLE: begin
        miso_d = 1'b0;
        if (cs_fall) begin
          state_d   = SHIFT;
          tx_sh_d   = tx_data;
          rx_sh_d   = '0;
          bit_cnt_d = '0;
          miso_d    = tx_data[frame_bits-1];
          busy_d    = 1'b1;
        end
      end
      SHIFT: begin
        // CS rising wins over a coincident SCLK edge, which is dropped.
        if (cs_rise) begin
          state_d = DONE;
          miso_d  = 1'b0;
        end else begin
          if (sample_edge) begin
            rx_sh_d = {rx_sh_q[frame_bits-2:0], mosi_level};
            if (bit_cnt_q != CntMax) begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
          if (drive_edge) begin
            tx_sh_d = tx_sh_q << 1;
            miso_d  = (bit_cnt_q >= CntFull) ? 1'b0 : tx_sh_q[frame_bits-2];
          end
        end
      end
      DONE: begin
`ifdef SPI_SLV_FRAME_CHECK_EN
        if (bit_cnt_q == CntFull) begin
          rx_addr_d  = rx_sh_q[frame_bits-1 -: SPI_ADDR_W];
          rx_data_d  = rx_sh_q[SPI_DATA_W-1:0];
          rx_valid_d = 1'b1;
        end else begin
          frame_err_d = 1'b1;
        end
`else
        rx_addr_d  = rx_sh_q[frame_bits-1 -: SPI_ADDR_W];
        rx_data_d  = rx_sh_q[SPI_DATA_W-1:0];
        rx_valid_d = 1'b1;
`endif
        miso_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      bit_cnt_q  <= '0;
      miso_q     <= 1'b0;
      rx_addr_q  <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      bit_cnt_q  <= bit_cnt_d;
      miso_q     <= miso_d;
      rx_addr_q  <= rx_addr_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      busy_q     <= busy_d;
    end
  end

`ifdef SPI_SLV_FRAME_CHECK_EN
  logic frame_err_q;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= frame_err_d;
    end
  end
  assign frame_err = frame_err_q;
`else
  logic unused_frame_err;
  assign unused_frame_err = frame_err_d;
  assign frame_err        = 1'b0;
`endif

  assign MISO     = miso_q;
  assign rx_addr  = rx_addr_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = busy_q;

endmodule
